bus_ctrl_multi: RTL and testbench
=================================

BUS_CTRL_MULTI -- requirements
Module: bus_ctrl_multi

Interface
REQ-001 Parameter NUM_DEV, default 4, number of memory-mapped device channels, legal 1..16.
REQ-002 Parameter DEV_BASE, default 32'h000F_FF00, base of the device window; device i occupies 16 bytes at DEV_BASE + 16*i.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles without device ack, legal 1..255.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_bc_req  in  1  CPU transaction request, sampled in IDLE only.
REQ-007 cpu_bc_addr  in  32  CPU byte address.
REQ-008 cpu_bc_data  in  32  CPU write data.
REQ-009 cpu_bc_we  in  1  1 = write, 0 = read.
REQ-010 bc_cpu_data  out  32  read data, valid while bc_cpu_ack = 1.
REQ-011 bc_cpu_ack  out  1  one-cycle completion pulse.
REQ-012 bc_cpu_err  out  1  one-cycle error pulse, for unmapped address or timeout.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mem_sel  out  1  memory-region select.
REQ-015 select  out  NUM_DEV  one-hot device select.
REQ-016 bc_BE_addr  out  4  offset within the device window (latched cpu_bc_addr[3:0]).
REQ-017 bc_BE_data  out  32  latched write data to devices and memory.
REQ-018 bc_BE_we  out  1  write strobe.
REQ-019 dev_ack  in  NUM_DEV  per-device completion; a bit is ignored unless that device is selected.
REQ-020 dev_rdata  in  32*NUM_DEV  device i read data on bits [32i+31:32i].
REQ-021 mem_rdata  in  32  memory read data.

Function
REQ-022 The FSM SHALL have three states, IDLE, ACCESS and RESP, all outputs registered.
REQ-023 Decode in IDLE, on cpu_bc_req = 1: addr[31:16] == 0 is the memory region; addr[31:4] == DEV_BASE[31:4] + i with i < NUM_DEV is device i; any other address is unmapped.
REQ-024 IDLE with req to a mapped address: latch addr[3:0], data and we; assert mem_sel or select[i] on the next edge; go to ACCESS.
REQ-025 IDLE with req to an unmapped address: go to RESP with bc_cpu_err = 1, bc_cpu_ack = 0 and bc_cpu_data = 0; no select is asserted.
REQ-026 Select lines SHALL stay asserted for every ACCESS cycle and deassert on the edge that leaves ACCESS.
REQ-027 bc_BE_we SHALL equal the latched we for the first ACCESS cycle only, and be 0 otherwise, so that one write is issued per transaction.
REQ-028 Memory access SHALL complete after exactly one ACCESS cycle with no ack required; on a read, mem_rdata is captured.
REQ-029 Device access SHALL complete in the first ACCESS cycle in which dev_ack[i] = 1, including the first cycle; on a read, dev_rdata slice i is captured.
REQ-030 Timeout: a 8-bit counter clears on ACCESS entry and increments each ACCESS cycle; when it reaches TIMEOUT-1 with no ack, the FSM goes to RESP with err = 1 and data = 0. An ack arriving in that same cycle wins.
REQ-031 RESP SHALL last exactly one cycle with either ack or err high (never both), and return to IDLE.
REQ-032 Write completions SHALL return bc_cpu_data = 0.
REQ-033 cpu_bc_req SHALL be ignored in ACCESS and RESP; the CPU holds or re-issues it.
REQ-034 Latency from req to ack: memory 2 cycles; device with immediate ack 2 cycles; unmapped 1 cycle.
REQ-035 bc_BE_addr and bc_BE_data SHALL hold their latched values until the next accepted request.

Reset
REQ-036 rst = 1 SHALL force state IDLE at once, asynchronously, including mid-ACCESS.
REQ-037 On reset, select, mem_sel, bc_BE_we, bc_cpu_ack, bc_cpu_err and busy SHALL be 0; bc_cpu_data, bc_BE_data, bc_BE_addr and the counter SHALL be 0.
REQ-038 After rst falls, the first request SHALL be accepted on the first clock edge.

Verification
REQ-039 Write 32'h1234_5678 to 32'h000F_FF14 with dev_ack[1] tied to 1 -> select = 4'b0010 and bc_BE_we = 1 for one cycle, bc_BE_data = 32'h1234_5678, bc_BE_addr = 4'h4, ack pulse 2 cycles after req.
REQ-040 Read 32'h0000_0100 with mem_rdata = 32'hCAFE_0001 -> mem_sel high for one cycle, bc_cpu_data = 32'hCAFE_0001 with ack.
REQ-041 Read 32'h000F_FF30 with dev_ack[3] rising 5 cycles after select and dev_rdata[127:96] = 32'hA5A5_A5A5 -> select[3] held 6 cycles, data A5A5_A5A5 with ack, bc_BE_we never 1.
REQ-042 Read 32'h000F_FF20 with dev_ack held 0 and TIMEOUT = 15 -> err pulse after 15 ACCESS cycles, data 0, no ack.
REQ-043 Request to 32'h0010_0000, and to 32'h000F_FF40 with NUM_DEV = 4 -> err 1 cycle after req, all selects 0.
REQ-044 rst asserted mid-ACCESS, with a second req issued during ACCESS -> the in-flight req is ignored; after reset busy = 0, select = 0, no ack or err is ever emitted for the aborted transaction.

Source files
------------

// File: rtl/bus_ctrl_multi_if.sv
// Bus controller handshake bundle: CPU side, device channels, memory.
// master = CPU/device/memory side, slave = bus controller.
interface bus_ctrl_multi_if #(
   parameter int NUM_DEV = 4
);
   logic                   cpu_bc_req;
   logic [31:0]            cpu_bc_addr;
   logic [31:0]            cpu_bc_data;
   logic                   cpu_bc_we;
   logic [31:0]            bc_cpu_data;
   logic                   bc_cpu_ack;
   logic                   bc_cpu_err;
   logic                   busy;
   logic                   mem_sel;
   logic [NUM_DEV-1:0]     select;
   logic [3:0]             bc_BE_addr;
   logic [31:0]            bc_BE_data;
   logic                   bc_BE_we;
   logic [NUM_DEV-1:0]     dev_ack;
   logic [32*NUM_DEV-1:0]  dev_rdata;
   logic [31:0]            mem_rdata;

   modport master (
      output cpu_bc_req, cpu_bc_addr, cpu_bc_data, cpu_bc_we,
      input  bc_cpu_data, bc_cpu_ack, bc_cpu_err, busy,
      input  mem_sel, select, bc_BE_addr, bc_BE_data, bc_BE_we,
      output dev_ack, dev_rdata, mem_rdata
   );

   modport slave (
      input  cpu_bc_req, cpu_bc_addr, cpu_bc_data, cpu_bc_we,
      output bc_cpu_data, bc_cpu_ack, bc_cpu_err, busy,
      output mem_sel, select, bc_BE_addr, bc_BE_data, bc_BE_we,
      input  dev_ack, dev_rdata, mem_rdata
   );
endinterface

// File: rtl/bus_ctrl_multi.sv
// Multi-device bus controller: decodes CPU requests to memory or
// device channels, runs one access with timeout, returns ack/err.
module bus_ctrl_multi #(
   parameter int          NUM_DEV  = 4,
   parameter logic [31:0] DEV_BASE = 32'h000F_FF00,
   parameter int          TIMEOUT  = 15
) (
   input  logic           clk,
   input  logic           rst,
   bus_ctrl_multi_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t             state_q;
   logic [NUM_DEV-1:0] sel_q;
   logic               mem_sel_q;
   logic               we_q;
   logic               be_we_q;
   logic [3:0]         be_addr_q;
   logic [31:0]        be_data_q;
   logic [31:0]        rdata_q;
   logic               ack_q;
   logic               err_q;
   logic               busy_q;
   logic [7:0]         cnt_q;

   logic               mem_hit_d;
   logic [NUM_DEV-1:0] dev_sel_d;
   logic               dev_hit_d;
   logic               dev_ack_d;
   logic [31:0]        dev_rd_d;

   // Address decode of the incoming request; memory wins on overlap.
   always_comb begin
      mem_hit_d = (bus.cpu_bc_addr[31:16] == 16'h0000);
      dev_sel_d = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (bus.cpu_bc_addr[31:4] == DEV_BASE[31:4] + 28'(i))
            dev_sel_d[i] = 1'b1;
      end
      if (mem_hit_d)
         dev_sel_d = '0;
      dev_hit_d = |dev_sel_d;
   end

   // Ack and read data of the currently selected device only.
   always_comb begin
      dev_ack_d = |(bus.dev_ack & sel_q);
      dev_rd_d  = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (sel_q[i])
            dev_rd_d = dev_rd_d | bus.dev_rdata[32*i +: 32];
      end
   end

   // Main FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         mem_sel_q <= 1'b0;
         we_q      <= 1'b0;
         be_we_q   <= 1'b0;
         be_addr_q <= 4'h0;
         be_data_q <= 32'h0;
         rdata_q   <= 32'h0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= 8'h00;
      end else begin
         unique case (state_q)
            IDLE: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= 32'h0;
               if (bus.cpu_bc_req) begin
                  busy_q <= 1'b1;
                  if (mem_hit_d || dev_hit_d) begin
                     be_addr_q <= bus.cpu_bc_addr[3:0];
                     be_data_q <= bus.cpu_bc_data;
                     we_q      <= bus.cpu_bc_we;
                     be_we_q   <= bus.cpu_bc_we;
                     mem_sel_q <= mem_hit_d;
                     sel_q     <= dev_sel_d;
                     cnt_q     <= 8'h00;
                     state_q   <= ACCESS;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
            ACCESS: begin
               // Only the first access cycle carries the write strobe.
               be_we_q <= 1'b0;
               if (mem_sel_q || dev_ack_d) begin
                  ack_q     <= 1'b1;
                  rdata_q   <= we_q ? 32'h0 :
                               mem_sel_q ? bus.mem_rdata :
                               dev_rd_d;
                  sel_q     <= '0;
                  mem_sel_q <= 1'b0;
                  state_q   <= RESP;
               end else if (cnt_q == TO_LAST) begin
                  err_q     <= 1'b1;
                  rdata_q   <= 32'h0;
                  sel_q     <= '0;
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q + 8'h01;
               end
            end
            RESP: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= 32'h0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.select      = sel_q;
   assign bus.mem_sel     = mem_sel_q;
   assign bus.bc_BE_we    = be_we_q;
   assign bus.bc_BE_addr  = be_addr_q;
   assign bus.bc_BE_data  = be_data_q;
   assign bus.bc_cpu_data = rdata_q;
   assign bus.bc_cpu_ack  = ack_q;
   assign bus.bc_cpu_err  = err_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bus_ctrl_multi.sv
// Directed testbench for bus_ctrl_multi.
// Hand-computed expectations for memory, device, timeout, reset.
module tb_bus_ctrl_multi;

   localparam int ND = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   bus_ctrl_multi_if #(.NUM_DEV(ND)) bus ();

   bus_ctrl_multi #(
      .NUM_DEV (ND),
      .DEV_BASE(32'h000F_FF00),
      .TIMEOUT (15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic w);
      bus.cpu_bc_req  = 1'b1;
      bus.cpu_bc_addr = a;
      bus.cpu_bc_data = d;
      bus.cpu_bc_we   = w;
      tick();
      bus.cpu_bc_req  = 1'b0;
   endtask

   initial begin
      int n;
      logic seen;
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      bus.cpu_bc_req  = 1'b0;
      bus.cpu_bc_addr = 32'h0;
      bus.cpu_bc_data = 32'h0;
      bus.cpu_bc_we   = 1'b0;
      bus.dev_ack     = '0;
      bus.dev_rdata   = '0;
      bus.mem_rdata   = 32'h0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_sel", 32'(bus.select), 32'h0);
      chk("rst_msel", 32'(bus.mem_sel), 32'h0);
      chk("rst_ack", 32'(bus.bc_cpu_ack), 32'h0);
      chk("rst_err", 32'(bus.bc_cpu_err), 32'h0);
      chk("rst_we", 32'(bus.bc_BE_we), 32'h0);
      chk("rst_data", bus.bc_cpu_data, 32'h0);
      chk("rst_bdata", bus.bc_BE_data, 32'h0);
      chk("rst_baddr", 32'(bus.bc_BE_addr), 32'h0);

      // Device 1 write, immediate ack, first edge after reset
      rst = 1'b0;
      bus.dev_ack = 4'b0010;
      issue(32'h000F_FF14, 32'h1234_5678, 1'b1);
      chk("w1_sel", 32'(bus.select), 32'h2);
      chk("w1_we", 32'(bus.bc_BE_we), 32'h1);
      chk("w1_bdata", bus.bc_BE_data, 32'h1234_5678);
      chk("w1_baddr", 32'(bus.bc_BE_addr), 32'h4);
      chk("w1_busy", 32'(bus.busy), 32'h1);
      chk("w1_ack0", 32'(bus.bc_cpu_ack), 32'h0);
      tick();
      chk("w1_ack", 32'(bus.bc_cpu_ack), 32'h1);
      chk("w1_err", 32'(bus.bc_cpu_err), 32'h0);
      chk("w1_data", bus.bc_cpu_data, 32'h0);
      chk("w1_we2", 32'(bus.bc_BE_we), 32'h0);
      chk("w1_sel2", 32'(bus.select), 32'h0);
      tick();
      chk("w1_ackend", 32'(bus.bc_cpu_ack), 32'h0);
      chk("w1_idle", 32'(bus.busy), 32'h0);
      chk("w1_hold", bus.bc_BE_data, 32'h1234_5678);
      bus.dev_ack = '0;

      // Memory read
      bus.mem_rdata = 32'hCAFE_0001;
      issue(32'h0000_0100, 32'h0, 1'b0);
      chk("mr_msel", 32'(bus.mem_sel), 32'h1);
      chk("mr_sel", 32'(bus.select), 32'h0);
      chk("mr_we", 32'(bus.bc_BE_we), 32'h0);
      tick();
      chk("mr_msel2", 32'(bus.mem_sel), 32'h0);
      chk("mr_ack", 32'(bus.bc_cpu_ack), 32'h1);
      chk("mr_data", bus.bc_cpu_data, 32'hCAFE_0001);
      tick();
      chk("mr_ackend", 32'(bus.bc_cpu_ack), 32'h0);

      // Memory write at top of memory region
      issue(32'h0000_FFFC, 32'hDEAD_BEEF, 1'b1);
      chk("mw_msel", 32'(bus.mem_sel), 32'h1);
      chk("mw_we", 32'(bus.bc_BE_we), 32'h1);
      chk("mw_baddr", 32'(bus.bc_BE_addr), 32'hC);
      tick();
      chk("mw_ack", 32'(bus.bc_cpu_ack), 32'h1);
      chk("mw_data", bus.bc_cpu_data, 32'h0);
      tick();

      // Device 3 read, ack in the 6th access cycle
      bus.dev_rdata[127:96] = 32'hA5A5_A5A5;
      bus.dev_rdata[31:0]   = 32'h1111_1111;
      issue(32'h000F_FF30, 32'h0, 1'b0);
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (bus.select == 4'b1000) n++;
         seen = seen | bus.bc_BE_we | bus.bc_cpu_ack;
         if (k == 5) bus.dev_ack = 4'b1000;
         tick();
      end
      chk("d3_selcyc", 32'(n), 32'd6);
      chk("d3_noweack", 32'(seen), 32'h0);
      chk("d3_ack", 32'(bus.bc_cpu_ack), 32'h1);
      chk("d3_data", bus.bc_cpu_data, 32'hA5A5_A5A5);
      chk("d3_sel", 32'(bus.select), 32'h0);
      bus.dev_ack = '0;
      tick();

      // Device 2 timeout; ack on unselected device 0 is ignored
      bus.dev_ack = 4'b0001;
      issue(32'h000F_FF20, 32'h0, 1'b0);
      n = 0;
      while (bus.select != '0 && !bus.bc_cpu_err && n < 40) begin
         n++;
         tick();
      end
      chk("to_cycles", 32'(n), 32'd15);
      chk("to_err", 32'(bus.bc_cpu_err), 32'h1);
      chk("to_ack", 32'(bus.bc_cpu_ack), 32'h0);
      chk("to_data", bus.bc_cpu_data, 32'h0);
      tick();
      chk("to_errend", 32'(bus.bc_cpu_err), 32'h0);
      chk("to_idle", 32'(bus.busy), 32'h0);
      bus.dev_ack = '0;

      // Ack in the last allowed cycle wins over timeout
      bus.dev_rdata[31:0] = 32'h0BAD_F00D;
      issue(32'h000F_FF00, 32'h0, 1'b0);
      for (int k = 0; k < 14; k++) tick();
      chk("late_sel", 32'(bus.select), 32'h1);
      bus.dev_ack = 4'b0001;
      tick();
      chk("late_ack", 32'(bus.bc_cpu_ack), 32'h1);
      chk("late_err", 32'(bus.bc_cpu_err), 32'h0);
      chk("late_data", bus.bc_cpu_data, 32'h0BAD_F00D);
      bus.dev_ack = '0;
      tick();

      // Unmapped addresses
      issue(32'h0010_0000, 32'h0, 1'b0);
      chk("u1_err", 32'(bus.bc_cpu_err), 32'h1);
      chk("u1_ack", 32'(bus.bc_cpu_ack), 32'h0);
      chk("u1_sel", 32'({bus.select, bus.mem_sel}), 32'h0);
      chk("u1_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("u1_errend", 32'(bus.bc_cpu_err), 32'h0);
      issue(32'h000F_FF40, 32'h0, 1'b1);
      chk("u2_err", 32'(bus.bc_cpu_err), 32'h1);
      chk("u2_sel", 32'({bus.select, bus.mem_sel}), 32'h0);
      chk("u2_we", 32'(bus.bc_BE_we), 32'h0);
      chk("u2_data", bus.bc_cpu_data, 32'h0);
      tick();

      // Reset mid-access with a second request pending
      issue(32'h000F_FF10, 32'h0, 1'b0);
      chk("ra_sel", 32'(bus.select), 32'h2);
      bus.cpu_bc_req  = 1'b1;
      bus.cpu_bc_addr = 32'h0000_0200;
      tick();
      chk("ra_ign", 32'({bus.select, bus.mem_sel}), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      chk("ra_busy", 32'(bus.busy), 32'h0);
      chk("ra_sel0", 32'(bus.select), 32'h0);
      bus.cpu_bc_req = 1'b0;
      seen = 1'b0;
      tick();
      seen = seen | bus.bc_cpu_ack | bus.bc_cpu_err;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen = seen | bus.bc_cpu_ack | bus.bc_cpu_err | bus.busy;
      end
      chk("ra_quiet", 32'(seen), 32'h0);
      chk("ra_sel1", 32'(bus.select), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
